// File: rtl/riscv_core_branch_resolve.sv
// Execute-stage branch resolution: condition evaluation, mispredict/redirect
// generation, 2-bit branch history table and a saturating mispredict counter.
module riscv_core_branch_resolve #(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 64,
    parameter bit C_EXT       = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_is_jump,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_srcA,
    input  logic [XLEN-1:0] i_srcB,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_compressed,
    input  logic            i_pred_taken,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_lookup_pc,
    output logic            o_lookup_taken,
    output logic            o_valid,
    output logic            o_taken,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_addr_misaligned,
    output logic [31:0]     o_mispredict_cnt
);

    localparam int IDX_W   = $clog2(BHT_ENTRIES);
    localparam int IDX_LSB = C_EXT ? 1 : 2;

    logic [1:0]      bht [BHT_ENTRIES];
    logic            cond_taken;
    logic            taken;
    logic            misaligned;
    logic            mispredict;
    logic            capture;
    logic            bht_update;
    logic [1:0]      align_mask;
    logic [XLEN-1:0] fall_through;
    logic [XLEN-1:0] redirect_pc;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic            unused_lookup_bits;

    always_comb begin
        cond_taken = 1'b0;
        case (i_funct3)
            3'b000:  cond_taken = (i_srcA == i_srcB);
            3'b001:  cond_taken = (i_srcA != i_srcB);
            3'b100:  cond_taken = ($signed(i_srcA) <  $signed(i_srcB));
            3'b101:  cond_taken = ($signed(i_srcA) >= $signed(i_srcB));
            3'b110:  cond_taken = (i_srcA <  i_srcB);
            3'b111:  cond_taken = (i_srcA >= i_srcB);
            default: cond_taken = 1'b0;
        endcase
    end

    // A misaligned taken target traps, so it must not also be reported as a mispredict.
    assign align_mask   = C_EXT ? 2'b01 : 2'b11;
    assign taken        = i_is_jump | cond_taken;
    assign misaligned   = taken && |(i_target[1:0] & align_mask);
    assign mispredict   = (taken != i_pred_taken) && !misaligned;
    assign fall_through = i_pc + (i_compressed ? XLEN'(2) : XLEN'(4));
    assign redirect_pc  = taken ? i_target : fall_through;
    assign capture      = i_valid && !i_stall && !i_flush;
    assign bht_update   = capture && !i_is_jump && !misaligned;

    assign upd_idx        = i_pc[IDX_LSB +: IDX_W];
    assign lookup_idx     = i_lookup_pc[IDX_LSB +: IDX_W];
    assign o_lookup_taken = bht[lookup_idx][1];
    assign unused_lookup_bits = ^{i_lookup_pc[XLEN-1:IDX_LSB+IDX_W], i_lookup_pc[IDX_LSB-1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid           <= 1'b0;
            o_taken           <= 1'b0;
            o_mispredict      <= 1'b0;
            o_addr_misaligned <= 1'b0;
            o_redirect_pc     <= '0;
        end else if (!i_stall) begin
            o_valid           <= capture;
            o_taken           <= capture && taken;
            o_mispredict      <= capture && mispredict;
            o_addr_misaligned <= capture && misaligned;
            o_redirect_pc     <= redirect_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mispredict_cnt <= '0;
        end else if (capture && mispredict && (o_mispredict_cnt != 32'hFFFF_FFFF)) begin
            o_mispredict_cnt <= o_mispredict_cnt + 32'd1;
        end
    end

    // Counters reset to weakly not-taken; lookup reads the pre-update value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < BHT_ENTRIES; k++) begin
                bht[k] <= 2'b01;
            end
        end else if (bht_update) begin
            if (taken && (bht[upd_idx] != 2'b11)) begin
                bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else if (!taken && (bht[upd_idx] != 2'b00)) begin
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_branch_resolve.sv
// Scoreboard bench for riscv_core_branch_resolve: one C_EXT=1 and one C_EXT=0
// instance share stimulus; directed vectors push hand-computed results.
module tb_riscv_core_branch_resolve;

    typedef struct {
        string       name;
        bit          sel;
        logic        vld;
        logic        tkn;
        logic        mis;
        logic        mal;
        logic [63:0] rpc;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        valid1, valid0;
    logic        is_jump;
    logic [2:0]  funct3;
    logic [63:0] src_a, src_b, pc, target, lookup_pc;
    logic        compressed, pred_taken, stall, flush;

    logic        lk1, vld1, tkn1, mis1, mal1;
    logic [63:0] rpc1;
    logic [31:0] cnt1;
    logic        lk0, vld0, tkn0, mis0, mal0;
    logic [63:0] rpc0;
    logic [31:0] cnt0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    riscv_core_branch_resolve #(.XLEN(64), .BHT_ENTRIES(64), .C_EXT(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .i_is_jump(is_jump),
        .i_funct3(funct3), .i_srcA(src_a), .i_srcB(src_b), .i_pc(pc),
        .i_target(target), .i_compressed(compressed), .i_pred_taken(pred_taken),
        .i_stall(stall), .i_flush(flush), .i_lookup_pc(lookup_pc),
        .o_lookup_taken(lk1), .o_valid(vld1), .o_taken(tkn1), .o_mispredict(mis1),
        .o_redirect_pc(rpc1), .o_addr_misaligned(mal1), .o_mispredict_cnt(cnt1)
    );

    riscv_core_branch_resolve #(.XLEN(64), .BHT_ENTRIES(64), .C_EXT(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid0), .i_is_jump(is_jump),
        .i_funct3(funct3), .i_srcA(src_a), .i_srcB(src_b), .i_pc(pc),
        .i_target(target), .i_compressed(compressed), .i_pred_taken(pred_taken),
        .i_stall(stall), .i_flush(flush), .i_lookup_pc(lookup_pc),
        .o_lookup_taken(lk0), .o_valid(vld0), .o_taken(tkn0), .o_mispredict(mis0),
        .o_redirect_pc(rpc0), .o_addr_misaligned(mal0), .o_mispredict_cnt(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational lookup, then queue the result.
    task automatic applyStimulus(
        input string name, input bit sel, input logic v, input logic j,
        input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
        input logic [63:0] p, input logic [63:0] t, input logic comp,
        input logic pred, input logic stl, input logic fl, input logic lk_exp,
        input logic e_vld, input logic e_tkn, input logic e_mis, input logic e_mal,
        input logic [63:0] e_rpc, input logic [31:0] e_cnt);
        exp_t e;
        valid1 = v && sel;
        valid0 = v && !sel;
        is_jump = j; funct3 = f3; src_a = a; src_b = b; pc = p; target = t;
        compressed = comp; pred_taken = pred; stall = stl; flush = fl;
        #1;
        checkOutput({name, ".lookup"}, {63'd0, lk1}, {63'd0, lk_exp});
        @(posedge clk);
        e.name = name; e.sel = sel; e.vld = e_vld; e.tkn = e_tkn; e.mis = e_mis;
        e.mal = e_mal; e.rpc = e_rpc; e.cnt = e_cnt;
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.sel) begin
                checkOutput({mon_e.name, ".valid"}, {63'd0, vld1}, {63'd0, mon_e.vld});
                checkOutput({mon_e.name, ".taken"}, {63'd0, tkn1}, {63'd0, mon_e.tkn});
                checkOutput({mon_e.name, ".mispredict"}, {63'd0, mis1}, {63'd0, mon_e.mis});
                checkOutput({mon_e.name, ".misaligned"}, {63'd0, mal1}, {63'd0, mon_e.mal});
                checkOutput({mon_e.name, ".cnt"}, {32'd0, cnt1}, {32'd0, mon_e.cnt});
                if (mon_e.vld) checkOutput({mon_e.name, ".redirect"}, rpc1, mon_e.rpc);
            end else begin
                checkOutput({mon_e.name, ".valid"}, {63'd0, vld0}, {63'd0, mon_e.vld});
                checkOutput({mon_e.name, ".taken"}, {63'd0, tkn0}, {63'd0, mon_e.tkn});
                checkOutput({mon_e.name, ".mispredict"}, {63'd0, mis0}, {63'd0, mon_e.mis});
                checkOutput({mon_e.name, ".misaligned"}, {63'd0, mal0}, {63'd0, mon_e.mal});
                checkOutput({mon_e.name, ".cnt"}, {32'd0, cnt0}, {32'd0, mon_e.cnt});
                if (mon_e.vld) checkOutput({mon_e.name, ".redirect"}, rpc0, mon_e.rpc);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        valid1 = 1'b0; valid0 = 1'b0; is_jump = 1'b0; funct3 = 3'b000;
        src_a = '0; src_b = '0; pc = '0; target = '0; lookup_pc = 64'h400;
        compressed = 1'b0; pred_taken = 1'b0; stall = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        checkOutput("reset.valid1", {63'd0, vld1}, 64'd0);
        checkOutput("reset.redirect1", rpc1, 64'd0);
        checkOutput("reset.cnt1", {32'd0, cnt1}, 64'd0);
        checkOutput("reset.valid0", {63'd0, vld0}, 64'd0);
        checkOutput("reset.cnt0", {32'd0, cnt0}, 64'd0);
        checkOutput("reset.lookup", {63'd0, lk1}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        //              name        sel v  j  f3      a      b      pc       target   c  pr st fl lk  vld tkn mis mal rpc      cnt
        applyStimulus("blt",        1, 1, 0, 3'b100, 64'd0, ONES,  64'h100, 64'h180, 0, 0, 0, 0, 0,  1,  0,  0,  0,  64'h104, 0);
        applyStimulus("bltu",       1, 1, 0, 3'b110, 64'd0, ONES,  64'h100, 64'h180, 0, 0, 0, 0, 0,  1,  1,  1,  0,  64'h180, 1);
        applyStimulus("beq_c",      1, 1, 0, 3'b000, 64'd5, 64'd6, 64'h200, 64'h280, 1, 1, 0, 0, 0,  1,  0,  1,  0,  64'h202, 2);
        applyStimulus("bgeu",       1, 1, 0, 3'b111, ONES,  64'd0, 64'h102, 64'h180, 0, 1, 0, 0, 0,  1,  1,  0,  0,  64'h180, 2);
        applyStimulus("f3_010",     1, 1, 0, 3'b010, 64'd9, 64'd9, 64'h104, 64'h180, 0, 0, 0, 0, 0,  1,  0,  0,  0,  64'h108, 2);
        applyStimulus("jal302_c1",  1, 1, 1, 3'b000, 64'd0, 64'd0, 64'h300, 64'h302, 0, 1, 0, 0, 0,  1,  1,  0,  0,  64'h302, 2);
        applyStimulus("jal301_c1",  1, 1, 1, 3'b000, 64'd0, 64'd0, 64'h300, 64'h301, 0, 0, 0, 0, 0,  1,  1,  0,  1,  64'h301, 2);
        applyStimulus("jal302_c0",  0, 1, 1, 3'b000, 64'd0, 64'd0, 64'h300, 64'h302, 0, 0, 0, 0, 0,  1,  1,  0,  1,  64'h302, 0);
        applyStimulus("jal301_c0",  0, 1, 1, 3'b000, 64'd0, 64'd0, 64'h300, 64'h301, 0, 1, 0, 0, 0,  1,  1,  0,  1,  64'h301, 0);
        applyStimulus("jal304_c0",  0, 1, 1, 3'b000, 64'd0, 64'd0, 64'h300, 64'h304, 0, 0, 0, 0, 0,  1,  1,  1,  0,  64'h304, 1);
        applyStimulus("bge_c0",     0, 1, 0, 3'b101, ONES,  64'd0, 64'h300, 64'h340, 0, 0, 0, 0, 0,  1,  0,  0,  0,  64'h304, 1);
        applyStimulus("beq_restore",1, 1, 0, 3'b000, 64'd7, 64'd7, 64'h500, 64'h540, 0, 1, 0, 0, 0,  1,  1,  0,  0,  64'h540, 2);
        applyStimulus("train_t1",   1, 1, 0, 3'b001, 64'd1, 64'd2, 64'h400, 64'h480, 0, 1, 0, 0, 0,  1,  1,  0,  0,  64'h480, 2);
        applyStimulus("train_t2",   1, 1, 0, 3'b001, 64'd1, 64'd2, 64'h400, 64'h480, 0, 1, 0, 0, 1,  1,  1,  0,  0,  64'h480, 2);
        applyStimulus("train_t3",   1, 1, 0, 3'b001, 64'd1, 64'd2, 64'h400, 64'h480, 0, 1, 0, 0, 1,  1,  1,  0,  0,  64'h480, 2);
        applyStimulus("train_t4",   1, 1, 0, 3'b001, 64'd1, 64'd2, 64'h400, 64'h480, 0, 1, 0, 0, 1,  1,  1,  0,  0,  64'h480, 2);
        applyStimulus("train_n1",   1, 1, 0, 3'b000, 64'd1, 64'd2, 64'h400, 64'h480, 0, 1, 0, 0, 1,  1,  0,  1,  0,  64'h404, 3);
        applyStimulus("train_n2",   1, 1, 0, 3'b000, 64'd1, 64'd2, 64'h400, 64'h480, 0, 0, 0, 0, 1,  1,  0,  0,  0,  64'h404, 3);
        applyStimulus("idle_a",     1, 0, 0, 3'b000, 64'd0, 64'd0, 64'h400, 64'h480, 0, 0, 0, 0, 0,  0,  0,  0,  0,  64'h0,   3);
        applyStimulus("mp_branch",  1, 1, 0, 3'b001, 64'd1, 64'd2, 64'h600, 64'h640, 0, 0, 0, 0, 0,  1,  1,  1,  0,  64'h640, 4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall",  1, 1, 0, 3'b000, 64'd3, 64'd4, 64'h700, 64'h740, 0, 1, 1, 0, 1,  1,  1,  1,  0,  64'h640, 4);
        end
        applyStimulus("flush",      1, 1, 0, 3'b000, 64'd3, 64'd4, 64'h700, 64'h740, 0, 1, 0, 1, 1,  0,  0,  0,  0,  64'h0,   4);
        applyStimulus("idle_b",     1, 0, 0, 3'b000, 64'd0, 64'd0, 64'h700, 64'h740, 0, 0, 0, 0, 1,  0,  0,  0,  0,  64'h0,   4);
        applyStimulus("to_sat",     1, 1, 0, 3'b001, 64'd1, 64'd2, 64'h400, 64'h480, 0, 1, 0, 0, 1,  1,  1,  0,  0,  64'h480, 4);

        // Asynchronous reset while a valid result is showing and the counter is saturated.
        valid1 = 1'b0; valid0 = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset.valid", {63'd0, vld1}, 64'd0);
        checkOutput("midreset.taken", {63'd0, tkn1}, 64'd0);
        checkOutput("midreset.redirect", rpc1, 64'd0);
        checkOutput("midreset.cnt", {32'd0, cnt1}, 64'd0);
        checkOutput("midreset.cnt0", {32'd0, cnt0}, 64'd0);
        checkOutput("midreset.lookup", {63'd0, lk1}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        applyStimulus("post_reset", 1, 0, 0, 3'b000, 64'd0, 64'd0, 64'h400, 64'h480, 0, 0, 0, 0, 0,  0,  0,  0,  0,  64'h0,   0);

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
